// File: rtl/ram_sync_if.sv
// Access bundle for ram_sync: request side driven by the client, read data and status returned.
// Carries no state of its own; all timing is defined by ram_sync.
// The client must hold off while busy_o is high; requests issued then are dropped.
interface ram_sync_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                  wen_i;
  logic                  ren_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] din_i;
  logic [DATA_WIDTH-1:0] dout_o;
  logic                  rvalid_o;
  logic                  busy_o;

  modport master (
    output wen_i, ren_i, addr_i, din_i,
    input  dout_o, rvalid_o, busy_o
  );

  modport slave (
    input  wen_i, ren_i, addr_i, din_i,
    output dout_o, rvalid_o, busy_o
  );
endinterface

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with a registered read port, a collision policy and a clear-after-reset sequencer.
// Read latency is 1 cycle. Writes become visible on the next edge, or on the same edge in write-first mode.
// There is no backpressure: accesses are dropped while busy_o is high, that is, during reset and during the clear sweep.
module ram_sync #(
  parameter int DATA_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ram_sync_if.slave   bus
);

  // Index width for the implemented words; kept at least 1 bit so DEPTH=1 still elaborates.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         cnt_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [IW-1:0]         addr_idx;
  logic                  last_clear;
  logic                  accept;

  // Out-of-range addresses are detected on the full address, so they can never alias onto a real word.
  assign in_range   = ({1'b0, bus.addr_i} < (ADDR_WIDTH+1)'(DEPTH));
  assign addr_idx   = bus.addr_i[IW-1:0];
  assign last_clear = (cnt_q == IW'(DEPTH - 1));
  assign accept     = (state_q == READY) && !rst_i;

  // Next-state logic and the single memory write port, shared by the clear sweep and user writes.
  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    mem_idx  = addr_idx;
    mem_wdat = bus.din_i;
    if (rst_i) begin
      state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we   = 1'b1;
          mem_idx  = cnt_q;
          mem_wdat = '0;
          if (last_clear) state_d = READY;
        end
        READY: begin
          mem_we = bus.wen_i && in_range;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State register, clear counter and registered busy flag. Busy is set by reset even when clearing is skipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == CLEAR);
      if (state_q == CLEAR) cnt_q <= cnt_q + IW'(1);
    end
  end

  // Storage array; reset deliberately leaves the contents alone.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_idx] <= mem_wdat;
  end

  // Registered read port. The non-blocking array update gives read-first data unless write-first is selected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept && bus.ren_i) begin
        rvalid_q <= 1'b1;
        if (!in_range)
          dout_q <= '0;
        else if ((WRITE_MODE == 1) && bus.wen_i)
          dout_q <= bus.din_i;
        else
          dout_q <= mem[addr_idx];
      end
    end
  end

  assign bus.dout_o   = dout_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync. Four instances share one stimulus stream:
// read-first with depth 16, write-first with depth 16, read-first with depth 12,
// and an instance that skips the clear sweep.
module tb_ram_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen;
  logic       ren;
  logic [3:0] addr;
  logic [3:0] din;

  int vectors    = 0;
  int miscompares = 0;

  ram_sync_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) if0 ();
  ram_sync_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) if1 ();
  ram_sync_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) if2 ();
  ram_sync_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) if3 ();

  assign if0.wen_i = wen;  assign if0.ren_i = ren;  assign if0.addr_i = addr;  assign if0.din_i = din;
  assign if1.wen_i = wen;  assign if1.ren_i = ren;  assign if1.addr_i = addr;  assign if1.din_i = din;
  assign if2.wen_i = wen;  assign if2.ren_i = ren;  assign if2.addr_i = addr;  assign if2.din_i = din;
  assign if3.wen_i = wen;  assign if3.ren_i = ren;  assign if3.addr_i = addr;  assign if3.din_i = din;

  ram_sync #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(16), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
    dut_rf (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  ram_sync #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(16), .WRITE_MODE(1), .CLEAR_ON_RESET(1))
    dut_wf (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  ram_sync #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(12), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
    dut_d12 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
  ram_sync #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(16), .WRITE_MODE(0), .CLEAR_ON_RESET(0))
    dut_nc (.clk_i(clk), .rst_i(rst), .bus(if3.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_d12 [12];
    exp_d12 = '{4'h3, 4'h5, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7};

    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = 4'h0; din = 4'h0;

    // Reset state after two reset cycles
    tick(); tick();
    check("rst_busy",    32'(if0.busy_o),   32'd1);
    check("rst_dout",    32'(if0.dout_o),   32'd0);
    check("rst_rvalid",  32'(if0.rvalid_o), 32'd0);
    check("rst_busy_nc", 32'(if3.busy_o),   32'd1);

    // Clear sweep: busy for exactly 16 edges. A write at clear cycle 2 and a read at cycle 4 are ignored.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wen = (i == 2); ren = (i == 4);
      addr = 4'h3; din = 4'hF;
      tick();
      check($sformatf("clr_busy_%0d", i),   32'(if0.busy_o),   32'(i < 15));
      check($sformatf("clr_rvalid_%0d", i), 32'(if0.rvalid_o), 32'd0);
      if (i == 0)  check("nc_busy_e0",  32'(if3.busy_o), 32'd0);
      if (i == 11) check("d12_busy_e11", 32'(if2.busy_o), 32'd0);
      if (i == 14) check("wf_busy_e14",  32'(if1.busy_o), 32'd1);
    end
    wen = 1'b0; ren = 1'b0;

    // First reads after the clear
    ren = 1'b1; addr = 4'h5; tick();
    check("rd5_dout",   32'(if0.dout_o),   32'd0);
    check("rd5_rvalid", 32'(if0.rvalid_o), 32'd1);
    addr = 4'h3; tick();
    check("rd3_dout",     32'(if0.dout_o), 32'd0);
    check("rd3_dout_d12", 32'(if2.dout_o), 32'd0);
    ren = 1'b0; tick();
    check("idle_rvalid", 32'(if0.rvalid_o), 32'd0);

    // Basic write then back-to-back reads
    wen = 1'b1; addr = 4'h0; din = 4'h3; tick();
    addr = 4'h1; din = 4'h5; tick();
    wen = 1'b0; ren = 1'b1; addr = 4'h0; tick();
    check("rd0_dout",   32'(if0.dout_o),   32'h3);
    check("rd0_rvalid", 32'(if0.rvalid_o), 32'd1);
    addr = 4'h1; tick();
    check("rd1_dout",   32'(if0.dout_o),   32'h5);
    check("rd1_rvalid", 32'(if0.rvalid_o), 32'd1);
    ren = 1'b0; tick();
    check("hold_dout",   32'(if0.dout_o),   32'h5);
    check("hold_rvalid", 32'(if0.rvalid_o), 32'd0);

    // Collision at addr 2 holding 0xA
    wen = 1'b1; addr = 4'h2; din = 4'hA; tick();
    ren = 1'b1; din = 4'h6; tick();
    check("coll_rf_dout", 32'(if0.dout_o), 32'hA);
    check("coll_wf_dout", 32'(if1.dout_o), 32'h6);
    check("coll_rvalid",  32'(if0.rvalid_o), 32'd1);
    wen = 1'b0; tick();
    check("coll_rf_after", 32'(if0.dout_o), 32'h6);
    check("coll_wf_after", 32'(if1.dout_o), 32'h6);
    ren = 1'b0;

    // Out of range on the depth-12 instance
    wen = 1'b1; addr = 4'hB; din = 4'h7; tick();
    addr = 4'hD; din = 4'h9; tick();
    wen = 1'b0; ren = 1'b1; addr = 4'hD; tick();
    check("oor_d12_dout",   32'(if2.dout_o),   32'h0);
    check("oor_d12_rvalid", 32'(if2.rvalid_o), 32'd1);
    check("oor_d16_dout",   32'(if0.dout_o),   32'h9);
    addr = 4'hB; tick();
    check("rd11_d12_dout", 32'(if2.dout_o), 32'h7);
    for (int a = 0; a < 12; a++) begin
      addr = 4'(a); tick();
      check($sformatf("d12_word_%0d", a), 32'(if2.dout_o), 32'(exp_d12[a]));
    end
    ren = 1'b0; tick();

    // Reset at clear cycle 7 restarts the full 16-edge sweep
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("mid_busy_%0d", i), 32'(if0.busy_o), 32'd1);
    end
    rst = 1'b1; tick();
    check("mid_rst_busy",   32'(if0.busy_o), 32'd1);
    check("mid_rst_dout",   32'(if0.dout_o), 32'd0);
    check("mid_rst_busy_nc", 32'(if3.busy_o), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("reclr_busy_%0d", i), 32'(if0.busy_o), 32'(i < 15));
    end
    ren = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); tick();
      check($sformatf("zero_rf_%0d", a),  32'(if0.dout_o),   32'd0);
      check($sformatf("zero_wf_%0d", a),  32'(if1.dout_o),   32'd0);
      check($sformatf("zero_rv_%0d", a),  32'(if0.rvalid_o), 32'd1);
    end
    ren = 1'b0; tick();
    check("end_rvalid", 32'(if0.rvalid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
# ram_sync

Parametrised synchronous single-port RAM with a registered read port, a read-valid strobe, a selectable read/write collision policy and a hardware clear sequencer. It replaces the fixed 4-bit × 4096 RAM as the CPU's main data memory. Geometry is set by parameters. After every reset, an FSM zeroes the array before the memory accepts any access.

## Interface
- `DATA_WIDTH`, 4: word width in bits.
- `ADDR_WIDTH`, 12: address width in bits.
- `DEPTH`, 2**ADDR_WIDTH: number of implemented words. Must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `WRITE_MODE`, 0: read/write collision policy. 0 = read-first (old data), 1 = write-first (new data).
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset; 0 = skip clearing.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `wen_i` input 1: write enable.
- `ren_i` input 1: read enable.
- `addr_i` input ADDR_WIDTH: word address.
- `din_i` input DATA_WIDTH: write data.
- `dout_o` output DATA_WIDTH: registered read data.
- `rvalid_o` output 1: one-cycle pulse; `dout_o` was updated by a read this edge.
- `busy_o` output 1: clear in progress; accesses are ignored while high.

## Operation
- FSM has two states: CLEAR and READY.
- Reset (`rst_i` high at an edge):
  - state ← CLEAR, or READY if CLEAR_ON_RESET=0;
  - clear counter ← 0;
  - `dout_o` ← 0, `rvalid_o` ← 0;
  - `busy_o` is 1 while `rst_i` is high, regardless of CLEAR_ON_RESET.
  - Memory contents are not touched by reset itself.
- CLEAR:
  - each edge writes 0 to mem[clear counter], then increments the counter;
  - at the edge that writes DEPTH-1, state ← READY;
  - `busy_o` = 1 throughout;
  - `wen_i`/`ren_i` are ignored; `rvalid_o` = 0; `dout_o` holds 0.
- READY (`busy_o` = 0):
  - `wen_i`=1 and addr < DEPTH: mem[addr] ← `din_i`.
  - `ren_i`=1: `dout_o` ← mem[addr], `rvalid_o` ← 1.
  - `ren_i`=0: `rvalid_o` ← 0 and `dout_o` holds its last value.
- Collision (`wen_i` and `ren_i` in the same cycle):
  - WRITE_MODE=0: `dout_o` gets the pre-write word.
  - WRITE_MODE=1: `dout_o` gets `din_i`.
  - The write is performed in both modes.
- Out of range (addr ≥ DEPTH):
  - write is dropped, with no aliasing;
  - read returns 0 with `rvalid_o` = 1.
- Reset asserted mid-clear or mid-access: abandons the current operation and restarts the clear from address 0. Words already cleared stay 0.
- CLEAR_ON_RESET=0: initial contents are undefined.

## Timing
- Read latency is 1 cycle. Inputs are sampled at edge N, and `dout_o`/`rvalid_o` are valid after edge N until edge N+1.
- Writes are visible to a read sampled at edge N+1 (or at edge N in WRITE_MODE=1).
- Clear duration: with `rst_i` low from edge E0, clearing writes occur at edges E0..E(DEPTH-1). `busy_o` falls after E(DEPTH-1). The first access is accepted at E(DEPTH).
- With CLEAR_ON_RESET=0, `busy_o` falls after E0, and the first access is accepted at E0 itself.
- Back-to-back reads are supported every cycle, and `rvalid_o` stays high continuously during them.
- No combinational path from any input to any output.

## Test plan
All scenarios use DATA_WIDTH=4, ADDR_WIDTH=4, DEPTH=16 unless a different value is stated.

1. **Reset and clear.** Hold `rst_i` for 2 cycles, then release.
   - `busy_o` stays 1 for exactly 16 edges, then goes 0.
   - A read of addr 5 then gives `dout_o`=0x0 with `rvalid_o`=1 for one cycle.
2. **Basic write/read.** Write 0x3 to addr 0, write 0x5 to addr 1, then read 0, then read 1.
   - `dout_o` = 0x3, then 0x5, on consecutive cycles, with `rvalid_o` high for both.
   - With `ren_i` low, `dout_o` holds 0x5 and `rvalid_o`=0.
3. **Collision.** With mem[2]=0xA, assert `wen_i` and `ren_i` at addr 2 with `din_i`=0x6.
   - WRITE_MODE=0: `dout_o`=0xA; a following read gives 0x6.
   - WRITE_MODE=1: `dout_o`=0x6.
4. **Access during clear.** Assert `wen_i` at addr 3 with `din_i`=0xF during CLEAR cycle 2, and `ren_i` at cycle 4.
   - `rvalid_o` stays 0 throughout.
   - After `busy_o` falls, a read of addr 3 returns 0x0.
5. **Reset mid-clear.** Assert `rst_i` for 1 cycle at clear cycle 7.
   - `busy_o` remains 1 for a full 16 edges after the second release.
   - All 16 words read back as 0.
6. **Out of range** (DEPTH=12). Write 0x9 to addr 13, then read addr 13, then read addr 11.
   - The read of addr 13 gives `dout_o`=0 with `rvalid_o`=1, and no word changes.
   - The read of addr 11 returns its stored value.
